dispatch_steer: RTL and testbench

Steers dispatched instruction packets into one of NUM_PIPES per-pipe schedulers (reservation stations). Sits between rename/dispatch and the scheduler array. Buffers up to BUF_DEPTH packets in order and picks a non-full pipe by round-robin. Returns the global producer tag (pipe * RS_ENTRIES + entry) so rename can record it in later dependency masks.

---
 rtl/dispatch_steer.sv | 137 +++++++++++++
 tb/tb_dispatch_steer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_steer.sv
// dispatch_steer: in-order staging buffer between rename/dispatch and the
// per-pipe scheduler array. The head packet is steered round-robin to the
// first non-full pipe, and its global producer tag is returned to rename.

package dispatch_pkg;
    parameter int NUM_FUS    = 2;
    parameter int RS_ENTRIES = 4;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [18:0] payload;
    } disp_packet_t;
endpackage

module dispatch_steer #(
    parameter int NUM_PIPES  = dispatch_pkg::NUM_FUS,
    parameter int BUF_DEPTH  = 4,
    parameter int RS_ENTRIES = dispatch_pkg::RS_ENTRIES,
    parameter int DEP_W      = RS_ENTRIES * NUM_PIPES,
    parameter int TAG_W      = $clog2(DEP_W),
    localparam int IDX_W     = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  dispatch_pkg::disp_packet_t in_pkt,
    input  logic [DEP_W-1:0]           in_dep_mask,
    input  logic [NUM_PIPES-1:0]       rs_full,
    input  logic [NUM_PIPES*IDX_W-1:0] rs_entry_idx,
    output logic [NUM_PIPES-1:0]       disp_valid,
    output dispatch_pkg::disp_packet_t disp_pkt,
    output logic [DEP_W-1:0]           disp_dep_mask,
    output logic [TAG_W-1:0]           disp_tag,
    output logic [31:0]                stall_cnt
);

    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PIPE_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    dispatch_pkg::disp_packet_t pkt_mem  [BUF_DEPTH];
    logic [DEP_W-1:0]           mask_mem [BUF_DEPTH];

    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count;
    logic [PIPE_W-1:0] rr_ptr;

    logic              enq;
    logic              active;
    logic              sel_found;
    logic [PIPE_W-1:0] sel_pipe;
    logic [PIPE_W-1:0] rr_next;
    logic              fire;
    logic              stall_evt;
    logic [IDX_W-1:0]  sel_entry;

    // Readiness looks only at the registered count, so a same-cycle dequeue never opens a slot.
    always_comb begin
        in_ready  = !rst && (count != CNT_W'(BUF_DEPTH));
        enq       = in_valid && in_ready;
        active    = !rst && !flush && (count != '0);
        fire      = active && sel_found;
        stall_evt = active && !sel_found;
    end

    // Round-robin search starting at rr_ptr for the first pipe with room.
    always_comb begin
        logic [PIPE_W:0] cand;
        sel_found = 1'b0;
        sel_pipe  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            cand = {1'b0, rr_ptr} + (PIPE_W+1)'(i);
            if (cand >= (PIPE_W+1)'(NUM_PIPES)) begin
                cand = cand - (PIPE_W+1)'(NUM_PIPES);
            end
            if (!sel_found && !rs_full[cand[PIPE_W-1:0]]) begin
                sel_found = 1'b1;
                sel_pipe  = cand[PIPE_W-1:0];
            end
        end
    end

    // Head packet is broadcast; the strobe, tag and next pointer follow the chosen pipe.
    always_comb begin
        disp_pkt      = pkt_mem[head_ptr];
        disp_dep_mask = mask_mem[head_ptr];
        sel_entry     = rs_entry_idx[int'(sel_pipe)*IDX_W +: IDX_W];
        disp_tag      = TAG_W'(sel_pipe) * TAG_W'(RS_ENTRIES) + TAG_W'(sel_entry);
        disp_valid    = fire ? (NUM_PIPES'(1) << sel_pipe) : '0;
        rr_next       = (int'(sel_pipe) == NUM_PIPES - 1) ? '0 : sel_pipe + PIPE_W'(1);
    end

    // Packet storage; flush and reset both discard a same-cycle write.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            pkt_mem[tail_ptr]  <= in_pkt;
            mask_mem[tail_ptr] <= in_dep_mask;
        end
    end

    // Pointers, occupancy, round-robin pointer and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            count     <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (fire) begin
                head_ptr <= head_ptr + PTR_W'(1);
                rr_ptr   <= rr_next;
            end
            if (enq && !fire) begin
                count <= count + CNT_W'(1);
            end else if (!enq && fire) begin
                count <= count - CNT_W'(1);
            end
            if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_steer.sv
// Self-checking bench for dispatch_steer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.

module tb_dispatch_steer;

    localparam int NP     = 2;
    localparam int DEPTH  = 4;
    localparam int RS_E   = 4;
    localparam int DEP_W  = 8;
    localparam int TAG_W  = 3;

    typedef struct packed {
        logic [31:0]      pkt;
        logic [DEP_W-1:0] mask;
    } entry_t;

    logic                       clk;
    logic                       rst;
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    dispatch_pkg::disp_packet_t in_pkt;
    logic [DEP_W-1:0]           in_dep_mask;
    logic [NP-1:0]              rs_full;
    logic [NP*2-1:0]            rs_entry_idx;
    logic [NP-1:0]              disp_valid;
    dispatch_pkg::disp_packet_t disp_pkt;
    logic [DEP_W-1:0]           disp_dep_mask;
    logic [TAG_W-1:0]           disp_tag;
    logic [31:0]                stall_cnt;

    entry_t      model_q[$];
    int          model_rr;
    logic [31:0] model_stall;

    logic             exp_ready;
    logic [NP-1:0]    exp_valid;
    logic [TAG_W-1:0] exp_tag;
    logic [31:0]      exp_pkt;
    logic [DEP_W-1:0] exp_mask;
    logic             exp_fire;
    int               exp_pipe;
    logic             exp_stall_evt;

    int checks;
    int errors;
    logic [31:0] held_pkt;
    logic [7:0]  held_mask;

    dispatch_steer dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pkt        (in_pkt),
        .in_dep_mask   (in_dep_mask),
        .rs_full       (rs_full),
        .rs_entry_idx  (rs_entry_idx),
        .disp_valid    (disp_valid),
        .disp_pkt      (disp_pkt),
        .disp_dep_mask (disp_dep_mask),
        .disp_tag      (disp_tag),
        .stall_cnt     (stall_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs for the current cycle from the model's view of the buffer.
    function automatic void computeExpect();
        int p;
        exp_ready     = !rst && (model_q.size() != DEPTH);
        exp_fire      = 1'b0;
        exp_pipe      = 0;
        exp_stall_evt = 1'b0;
        exp_tag       = '0;
        exp_pkt       = '0;
        exp_mask      = '0;
        if (!rst && !flush && model_q.size() != 0) begin
            for (int k = 0; k < NP; k++) begin
                p = (model_rr + k) % NP;
                if (!exp_fire && !rs_full[p]) begin
                    exp_fire = 1'b1;
                    exp_pipe = p;
                end
            end
            exp_stall_evt = !exp_fire;
        end
        exp_valid = exp_fire ? NP'(1 << exp_pipe) : '0;
        if (exp_fire) begin
            exp_tag  = TAG_W'(exp_pipe * RS_E + int'(rs_entry_idx[exp_pipe*2 +: 2]));
            exp_pkt  = model_q[0].pkt;
            exp_mask = model_q[0].mask;
        end
    endfunction

    // Compare DUT outputs against the model's expectations.
    task automatic checkOutput();
        computeExpect();
        checks++;
        assert (in_ready === exp_ready) else begin
            errors++;
            $error("[TB] FAIL in_ready: got %0b expected %0b", in_ready, exp_ready);
        end
        checks++;
        assert (disp_valid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL disp_valid: got %b expected %b", disp_valid, exp_valid);
        end
        checks++;
        assert (stall_cnt === model_stall) else begin
            errors++;
            $error("[TB] FAIL stall_cnt: got %0d expected %0d", stall_cnt, model_stall);
        end
        if (exp_fire) begin
            checks++;
            assert (disp_tag === exp_tag) else begin
                errors++;
                $error("[TB] FAIL disp_tag: got %0d expected %0d", disp_tag, exp_tag);
            end
            checks++;
            assert (disp_pkt === exp_pkt) else begin
                errors++;
                $error("[TB] FAIL disp_pkt: got %h expected %h", disp_pkt, exp_pkt);
            end
            checks++;
            assert (disp_dep_mask === exp_mask) else begin
                errors++;
                $error("[TB] FAIL disp_dep_mask: got %h expected %h", disp_dep_mask, exp_mask);
            end
        end
    endtask

    // Advance the model across the clock edge using the inputs of the cycle.
    function automatic void modelUpdate();
        if (rst) begin
            model_q.delete();
            model_rr    = 0;
            model_stall = '0;
        end else if (flush) begin
            model_q.delete();
        end else begin
            if (exp_fire) begin
                void'(model_q.pop_front());
                model_rr = (exp_pipe + 1) % NP;
            end
            if (exp_stall_evt && model_stall != 32'hFFFF_FFFF) begin
                model_stall = model_stall + 32'd1;
            end
            if (in_valid && exp_ready) begin
                model_q.push_back({32'(in_pkt), in_dep_mask});
            end
        end
    endfunction

    // Drive one cycle of inputs at the falling edge, check, then step the model.
    task automatic applyStimulus(input logic r, input logic iv, input logic fl,
                                 input logic [NP-1:0] full,
                                 input logic [31:0] pkt, input logic [7:0] mask);
        @(negedge clk);
        rst          = r;
        in_valid     = iv;
        flush        = fl;
        rs_full      = full;
        in_pkt       = pkt;
        in_dep_mask  = mask;
        rs_entry_idx = 4'($urandom);
        #1;
        checkOutput();
        @(posedge clk);
        modelUpdate();
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        checks       = 0;
        errors       = 0;
        model_rr     = 0;
        model_stall  = '0;
        rst          = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        rs_full      = '0;
        in_pkt       = '0;
        in_dep_mask  = '0;
        rs_entry_idx = '0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, $urandom, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, $urandom, 8'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, $urandom, 8'($urandom));

        $display("[TB] alternating pipes");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, $urandom, 8'($urandom));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, $urandom, 8'($urandom));

        $display("[TB] all pipes full with one packet");
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, $urandom, 8'($urandom));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, $urandom, 8'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, $urandom, 8'($urandom));
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, $urandom, 8'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, $urandom, 8'($urandom));

        $display("[TB] buffer full with held offer");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, $urandom, 8'($urandom));
        held_pkt  = $urandom;
        held_mask = 8'($urandom);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, held_pkt, held_mask);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, held_pkt, held_mask);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, held_pkt, held_mask);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, $urandom, 8'($urandom));

        $display("[TB] flush with offer");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, $urandom, 8'($urandom));
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, $urandom, 8'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, $urandom, 8'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, $urandom, 8'($urandom));

        $display("[TB] pointer wrap streaming");
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, $urandom, 8'($urandom));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, $urandom, 8'($urandom));

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 15) == 0),
                          2'($urandom_range(0, 3)),
                          $urandom, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
